// File: rtl/me_pkg.sv
// Shared motion-estimation types: pixel/block geometry, SAD widths, search FSM states.
// Combinational helpers only; no latency or flow control of its own.
package me_pkg;
  localparam int PIX_W     = 8;
  localparam int BLK_DIM   = 4;
  localparam int SAD_W     = 12;
  localparam int ROW_W     = PIX_W * BLK_DIM;
  localparam int ROW_SAD_W = 10;

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_e;

  typedef logic [BLK_DIM-1:0][PIX_W-1:0] row_t;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction
endpackage

// File: rtl/sad_row_unit.sv
// Row SAD: four unsigned 8-bit absolute differences summed into 10 bits.
// Latency: purely combinational; backpressure: none (no state).
module sad_row_unit
  import me_pkg::*;
(
  input  logic [ROW_W-1:0]     cur_row,
  input  logic [ROW_W-1:0]     ref_row,
  output logic [ROW_SAD_W-1:0] row_sad
);
  row_t             cur_pix;
  row_t             ref_pix;
  logic [PIX_W:0]   sum_lo;
  logic [PIX_W:0]   sum_hi;

  always_comb begin
    cur_pix = cur_row;
    ref_pix = ref_row;
    sum_lo  = {1'b0, abs_diff(cur_pix[0], ref_pix[0])} + {1'b0, abs_diff(cur_pix[1], ref_pix[1])};
    sum_hi  = {1'b0, abs_diff(cur_pix[2], ref_pix[2])} + {1'b0, abs_diff(cur_pix[3], ref_pix[3])};
    row_sad = {1'b0, sum_lo} + {1'b0, sum_hi};
  end
endmodule

// File: rtl/sad_search_engine.sv
// 4x4 SAD block search with min tracking; optional SAD_EARLY_TERM_EN adds skip_cnt.
// Latency: done 2 edges after the last accepted beat; backpressure: ref_ready drops once all beats are taken.
module sad_search_engine
  import me_pkg::*;
#(
  parameter int NUM_CAND = 64,
  parameter int IDX_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  input  logic             cur_valid,
  input  logic [ROW_W-1:0] cur_row0,
  input  logic [ROW_W-1:0] cur_row1,
  input  logic [ROW_W-1:0] cur_row2,
  input  logic [ROW_W-1:0] cur_row3,
  input  logic             ref_valid,
  output logic             ref_ready,
  input  logic [ROW_W-1:0] ref_data,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx
`ifdef SAD_EARLY_TERM_EN
  ,
  output logic [IDX_W:0]   skip_cnt
`endif
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  state_e                         state_q, state_d;
  logic                           busy_q, busy_d, ref_ready_q, ref_ready_d, done_q, done_d;
  logic [BLK_DIM-1:0][ROW_W-1:0]  cur_blk_q, cur_blk_d;
  logic [1:0]                     row_q, row_d;
  logic [IDX_W-1:0]               cand_q, cand_d;
  logic                           s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [ROW_SAD_W-1:0]           s1_sad_q, s1_sad_d;
  logic [IDX_W-1:0]               s1_idx_q, s1_idx_d;
  logic [SAD_W-1:0]               acc_q, acc_d, best_sad_q, best_sad_d;
  logic [IDX_W-1:0]               best_idx_q, best_idx_d;
`ifdef SAD_EARLY_TERM_EN
  logic                           skip_q, skip_d;
  logic [IDX_W:0]                 skip_cnt_q, skip_cnt_d;
`endif

  logic [ROW_SAD_W-1:0] row_sad;
  logic [SAD_W-1:0]     partial;
  logic                 accept;

  sad_row_unit u_row (
    .cur_row (cur_blk_q[row_q]),
    .ref_row (ref_data),
    .row_sad (row_sad)
  );

  always_comb begin
    accept      = ref_valid && ref_ready_q;
    partial     = acc_q + SAD_W'(s1_sad_q);
    state_d     = state_q;
    ref_ready_d = ref_ready_q;
    cur_blk_d   = cur_blk_q;
    row_d       = row_q;
    cand_d      = cand_q;
    s1_vld_d    = accept;
    s1_sad_d    = s1_sad_q;
    s1_last_d   = s1_last_q;
    s1_idx_d    = s1_idx_q;
    acc_d       = acc_q;
    best_sad_d  = best_sad_q;
    best_idx_d  = best_idx_q;
`ifdef SAD_EARLY_TERM_EN
    skip_d      = skip_q;
    skip_cnt_d  = skip_cnt_q;
`endif

    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (cur_valid) begin
          cur_blk_d   = {cur_row3, cur_row2, cur_row1, cur_row0};
          row_d       = 2'd0;
          cand_d      = '0;
          ref_ready_d = 1'b1;
          state_d     = SEARCH;
`ifdef SAD_EARLY_TERM_EN
          skip_cnt_d  = '0;
`endif
        end
      end
      SEARCH: begin
        if (accept) begin
          row_d = row_q + 2'd1;
          if (row_q == 2'd3) begin
            cand_d = cand_q + IDX_W'(1);
            if (cand_q == LAST_IDX) ref_ready_d = 1'b0;
          end
        end
        if (s1_vld_q && s1_last_q && (s1_idx_q == LAST_IDX)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      s1_sad_d  = row_sad;
      s1_last_d = (row_q == 2'd3);
      s1_idx_d  = cand_q;
    end

    // Stage 2: accumulate, and on the last row compare against the running best.
    if (s1_vld_q) begin
`ifdef SAD_EARLY_TERM_EN
      if (skip_q) begin
        if (s1_last_q) begin
          skip_d     = 1'b0;
          acc_d      = '0;
          skip_cnt_d = skip_cnt_q + (IDX_W+1)'(1);
        end
      end else
`endif
      if (s1_last_q) begin
        acc_d = '0;
        if ((s1_idx_q == '0) || (partial < best_sad_q)) begin
          best_sad_d = partial;
          best_idx_d = s1_idx_q;
        end
      end
`ifdef SAD_EARLY_TERM_EN
      else if ((s1_idx_q != '0) && (partial >= best_sad_q)) begin
        skip_d = 1'b1;
        acc_d  = '0;
      end
`endif
      else begin
        acc_d = partial;
      end
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      ref_ready_q <= 1'b0;
      done_q      <= 1'b0;
      cur_blk_q   <= '0;
      row_q       <= 2'd0;
      cand_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_sad_q    <= '0;
      s1_last_q   <= 1'b0;
      s1_idx_q    <= '0;
      acc_q       <= '0;
      best_sad_q  <= '0;
      best_idx_q  <= '0;
`ifdef SAD_EARLY_TERM_EN
      skip_q      <= 1'b0;
      skip_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      ref_ready_q <= ref_ready_d;
      done_q      <= done_d;
      cur_blk_q   <= cur_blk_d;
      row_q       <= row_d;
      cand_q      <= cand_d;
      s1_vld_q    <= s1_vld_d;
      s1_sad_q    <= s1_sad_d;
      s1_last_q   <= s1_last_d;
      s1_idx_q    <= s1_idx_d;
      acc_q       <= acc_d;
      best_sad_q  <= best_sad_d;
      best_idx_q  <= best_idx_d;
`ifdef SAD_EARLY_TERM_EN
      skip_q      <= skip_d;
      skip_cnt_q  <= skip_cnt_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign ref_ready = ref_ready_q;
  assign done      = done_q;
  assign best_sad  = best_sad_q;
  assign best_idx  = best_idx_q;
`ifdef SAD_EARLY_TERM_EN
  assign skip_cnt  = skip_cnt_q;
`endif
endmodule

// File: tb/tb_sad_search_engine.sv
// Directed bench for sad_search_engine: a 4-candidate and a 1-candidate instance share stimulus.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sad_search_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start4 = 1'b0, start1 = 1'b0;
  logic        cur_valid = 1'b0, ref_valid = 1'b0;
  logic [31:0] cur_row0 = '0, cur_row1 = '0, cur_row2 = '0, cur_row3 = '0;
  logic [31:0] ref_data = '0;

  logic        busy4, rr4, done4;
  logic [11:0] bs4;
  logic [1:0]  bi4;
  logic        busy1, rr1, done1;
  logic [11:0] bs1;
  logic [0:0]  bi1;
`ifdef SAD_EARLY_TERM_EN
  logic [2:0]  sk4;
  logic [1:0]  sk1;
`endif

  int          tests = 0;
  int          fails = 0;
  logic [31:0] refq[$];

  always #5 clk = ~clk;

  sad_search_engine #(.NUM_CAND(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .busy(busy4),
    .cur_valid(cur_valid), .cur_row0(cur_row0), .cur_row1(cur_row1),
    .cur_row2(cur_row2), .cur_row3(cur_row3),
    .ref_valid(ref_valid), .ref_ready(rr4), .ref_data(ref_data),
    .done(done4), .best_sad(bs4), .best_idx(bi4)
`ifdef SAD_EARLY_TERM_EN
    , .skip_cnt(sk4)
`endif
  );

  sad_search_engine #(.NUM_CAND(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1),
    .cur_valid(cur_valid), .cur_row0(cur_row0), .cur_row1(cur_row1),
    .cur_row2(cur_row2), .cur_row3(cur_row3),
    .ref_valid(ref_valid), .ref_ready(rr1), .ref_data(ref_data),
    .done(done1), .best_sad(bs1), .best_idx(bi1)
`ifdef SAD_EARLY_TERM_EN
    , .skip_cnt(sk1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cur(input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] r3);
    cur_row0 = r0; cur_row1 = r1; cur_row2 = r2; cur_row3 = r3;
  endtask

  task automatic push4(input logic [31:0] r);
    repeat (4) refq.push_back(r);
  endtask

  task automatic search(input string tag, input bit use1, input bit gaps, input bit poke,
                        input logic [11:0] exp_sad, input logic [31:0] exp_idx);
    int k;
    int cyc;
    int nb;
    bit rdy;
    bit acc;
    nb = refq.size();
    @(negedge clk);
    if (use1) start1 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    chk({tag, "_load_rdy"}, use1 ? rr1 : rr4, 0);
    chk({tag, "_load_busy"}, use1 ? busy1 : busy4, 1);
    cur_valid = 1'b1;
    @(negedge clk);
    cur_valid = 1'b0;
    k = 0;
    cyc = 0;
    while (k < nb && cyc < 500) begin
      rdy       = use1 ? rr1 : rr4;
      ref_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      ref_data  = refq[k];
      if (use1) start1 = poke && (cyc == 3); else start4 = poke && (cyc == 3);
      acc = ref_valid && rdy;
      @(negedge clk);
      if (acc) k++;
      cyc++;
    end
    ref_valid = 1'b0; start1 = 1'b0; start4 = 1'b0;
    chk({tag, "_beats"}, k, nb);
    chk({tag, "_rdy_drop"}, use1 ? rr1 : rr4, 0);
    chk({tag, "_done_t"}, use1 ? done1 : done4, 0);
    @(negedge clk);
    chk({tag, "_done_t1"}, use1 ? done1 : done4, 1);
    chk({tag, "_best_sad"}, use1 ? bs1 : bs4, exp_sad);
    chk({tag, "_best_idx"}, use1 ? 32'(bi1) : 32'(bi4), exp_idx);
    @(negedge clk);
    chk({tag, "_done_t2"}, use1 ? done1 : done4, 0);
    chk({tag, "_idle"}, use1 ? busy1 : busy4, 0);
    refq.delete();
  endtask

  initial begin
    // Reset held with the clock running.
    repeat (3) @(negedge clk);
    chk("rst_busy", busy4, 0);
    chk("rst_rdy", rr4, 0);
    chk("rst_done", done4, 0);
    chk("rst_sad", bs4, 0);
    chk("rst_idx", bi4, 0);
    chk("rst_sad1", bs1, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_rdy", rr4, 0);
    chk("post_rst_busy", busy4, 0);

    // Tie at SAD 0 keeps candidate 1.
    set_cur(32'h20202020, 32'h20202020, 32'h20202020, 32'h20202020);
    push4(32'h30303030); push4(32'h20202020); push4(32'h00000000); push4(32'h20202020);
    search("A", 1'b0, 1'b0, 1'b0, 12'd0, 1);

    // Decreasing SADs 512, 256, 256 (tie), 16.
    push4(32'h00000000); push4(32'h10101010); push4(32'h30303030); push4(32'h1F1F1F1F);
    search("C", 1'b0, 1'b0, 1'b0, 12'd16, 3);

    // Maximum SAD on the single-candidate instance.
    set_cur(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000);
    push4(32'hFFFFFFFF);
    search("MAX", 1'b1, 1'b0, 1'b0, 12'd4080, 0);

    // Lane ordering and absolute difference: 127 + 1 + 0 + 127.
    set_cur(32'h01FF0080, 32'h11223344, 32'h55667788, 32'h99AABBCC);
    refq.push_back(32'h80FF01FF); refq.push_back(32'h11223344);
    refq.push_back(32'h55667788); refq.push_back(32'h99AABBCC);
    search("LANE", 1'b1, 1'b0, 1'b0, 12'd255, 0);

    // Reset mid-search clears outputs in the same cycle.
    set_cur(32'h20202020, 32'h20202020, 32'h20202020, 32'h20202020);
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0; cur_valid = 1'b1;
    @(negedge clk); cur_valid = 1'b0; ref_valid = 1'b1; ref_data = 32'h30303030;
    repeat (2) @(negedge clk);
    chk("mid_hold_sad", bs4, 16);
    chk("mid_busy", busy4, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy4, 0);
    chk("mid_rst_rdy", rr4, 0);
    chk("mid_rst_done", done4, 0);
    chk("mid_rst_sad", bs4, 0);
    chk("mid_rst_idx", bi4, 0);
    ref_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // Gap-filled stream with a stray start pulse matches the clean run.
    push4(32'h30303030); push4(32'h20202020); push4(32'h00000000); push4(32'h20202020);
    search("GAPS", 1'b0, 1'b1, 1'b1, 12'd0, 1);
    repeat (2) @(negedge clk);
    chk("gaps_still_idle", busy4, 0);

    // Candidate 0 perfect, the rest differ from row 0 onward.
    push4(32'h20202020); push4(32'h30303030); push4(32'h30303030); push4(32'h30303030);
    search("ET", 1'b0, 1'b0, 1'b0, 12'd0, 0);
`ifdef SAD_EARLY_TERM_EN
    chk("ET_skip_cnt", sk4, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
